// File: rtl/bank_pkg.sv
// Shared types and defaults for the reg_bank register file.
package bank_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NUM_REGS = 8;

  // Bit offset of entry idx inside the packed starting-value vector.
  function automatic int start_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Write, restore and dual-read bus of the register bank.
interface reg_bank_if #(
  parameter int WIDTH    = bank_pkg::DEF_WIDTH,
  parameter int NUM_REGS = bank_pkg::DEF_NUM_REGS
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                      en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [WIDTH-1:0]          d_in;
  logic [NUM_REGS*WIDTH-1:0] starting;
  logic                      restore;
  logic [ADDR_W-1:0]         rd_addr_a;
  logic [ADDR_W-1:0]         rd_addr_b;
  logic [WIDTH-1:0]          rd_data_a;
  logic [WIDTH-1:0]          rd_data_b;
  logic                      wr_accepted;
  logic                      busy;
  logic                      restore_done;

  modport master (
    output en, wr_addr, d_in, starting, restore, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_accepted, busy, restore_done
  );

  modport slave (
    input  en, wr_addr, d_in, starting, restore, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_accepted, busy, restore_done
  );

endinterface

// File: rtl/reg_cell.sv
// One register: synchronous reset loads its starting value, i_load captures i_d.
module reg_cell #(
  parameter int WIDTH = bank_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_init,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)       r_q <= i_init;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_bank.sv
// Register bank with one write port, two combinational read ports and a restore sequencer.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank
  import bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank_if.slave  bus
);

  localparam int                ADDR_W   = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0]   LP_NREGS = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;
  logic              r_done;
  logic              w_wr_acc;
  logic              w_rst_load;
  logic [WIDTH-1:0]  w_q [NUM_REGS];
  logic [WIDTH-1:0]  w_rd_a;
  logic [WIDTH-1:0]  w_rd_b;

  always_comb begin
    w_next_state = r_state;
    w_wr_acc     = 1'b0;
    w_rst_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.restore)
          w_next_state = RESTORE;
        else if (bus.en && ({1'b0, bus.wr_addr} < LP_NREGS))
          w_wr_acc = 1'b1;
      end
      RESTORE: begin
        w_rst_load = 1'b1;
        if (r_idx == LP_LAST)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == RESTORE);
      r_done  <= (r_state == RESTORE) && (w_next_state == IDLE);
      // Clearing idx on exit keeps the walk correct for non-power-of-two depths.
      if (w_rst_load && (w_next_state == RESTORE))
        r_idx <= r_idx + ADDR_W'(1);
      else
        r_idx <= '0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    logic             w_load;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_init;

    assign w_init = bus.starting[start_lsb(i, WIDTH) +: WIDTH];
    assign w_load = (w_wr_acc && (bus.wr_addr == ADDR_W'(i))) ||
                    (w_rst_load && (r_idx == ADDR_W'(i)));
    assign w_d    = w_rst_load ? w_init : bus.d_in;

    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (clk),
      .reset  (reset),
      .i_init (w_init),
      .i_load (w_load),
      .i_d    (w_d),
      .o_q    (w_q[i])
    );
  end

  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if ({1'b0, bus.rd_addr_a} < LP_NREGS) w_rd_a = w_q[bus.rd_addr_a];
    if ({1'b0, bus.rd_addr_b} < LP_NREGS) w_rd_b = w_q[bus.rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
    if (w_wr_acc && (bus.rd_addr_a == bus.wr_addr)) w_rd_a = bus.d_in;
    if (w_wr_acc && (bus.rd_addr_b == bus.wr_addr)) w_rd_b = bus.d_in;
`endif
  end

  assign bus.rd_data_a    = w_rd_a;
  assign bus.rd_data_b    = w_rd_b;
  assign bus.wr_accepted  = w_wr_acc;
  assign bus.busy         = r_busy;
  assign bus.restore_done = r_done;

endmodule
